// File: rtl/load_store_unit.sv
// Load/store sequencer between the datapath and Data_Memory.
// Big-endian lanes; sub-word stores are done as read-modify-write.
module load_store_unit #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic                     LoadStore_CLOCK_50,
    input  logic                     LoadStore_RESET_InHigh,
    input  logic                     LoadStore_Start_In,
    input  logic                     LoadStore_Write_In,
    input  logic [1:0]               LoadStore_Size_In,
    input  logic                     LoadStore_Signed_In,
    input  logic [DATAWIDTH_BUS-1:0] LoadStore_Address_In,
    input  logic [DATAWIDTH_BUS-1:0] LoadStore_StoreData_In,
    input  logic [DATAWIDTH_BUS-1:0] LoadStore_MemData_In,
    output logic [DATAWIDTH_BUS-1:0] LoadStore_MemAddress_Out,
    output logic [DATAWIDTH_BUS-1:0] LoadStore_MemData_Out,
    output logic                     LoadStore_MemRD_Out,
    output logic                     LoadStore_MemWR_Out,
    output logic [DATAWIDTH_BUS-1:0] LoadStore_LoadData_Out,
    output logic                     LoadStore_Busy_Out,
    output logic                     LoadStore_Done_Out,
    output logic                     LoadStore_Error_Out
);

    localparam int         DW   = DATAWIDTH_BUS;
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic        wr_q;
    logic [15:0] sdata_q;

    logic          fault_in;
    logic          word_store_in;
    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;
    logic [DW-1:0] ext_data;
    logic [DW-1:0] merged;
    logic [DW-1:0] word_addr_in;

    // Classify the incoming request: fault and word-store shortcut
    always_comb begin
        fault_in = 1'b0;
        unique case (LoadStore_Size_In)
            2'b00: fault_in = 1'b0;
            2'b01: fault_in = LoadStore_Address_In[0];
            2'b10: fault_in = |LoadStore_Address_In[1:0];
            default: fault_in = 1'b1;
        endcase
        word_store_in = LoadStore_Write_In && (LoadStore_Size_In == 2'b10);
        word_addr_in  = {LoadStore_Address_In[DW-1:2], 2'b00};
    end

    // Pick the addressed lane of the memory word and extend it
    always_comb begin
        lane_byte = 8'h00;
        unique case (lane_q)
            2'b00: lane_byte = LoadStore_MemData_In[31:24];
            2'b01: lane_byte = LoadStore_MemData_In[23:16];
            2'b10: lane_byte = LoadStore_MemData_In[15:8];
            default: lane_byte = LoadStore_MemData_In[7:0];
        endcase
        lane_half = lane_q[1] ? LoadStore_MemData_In[15:0]
                              : LoadStore_MemData_In[31:16];
        ext_data = LoadStore_MemData_In;
        unique case (size_q)
            2'b00: ext_data = {{(DW-8){sgn_q & lane_byte[7]}}, lane_byte};
            2'b01: ext_data = {{(DW-16){sgn_q & lane_half[15]}}, lane_half};
            default: ext_data = LoadStore_MemData_In;
        endcase
    end

    // Splice the store operand into the fetched word for sub-word stores
    always_comb begin
        merged = LoadStore_MemData_In;
        if (size_q == 2'b00) begin
            unique case (lane_q)
                2'b00: merged[31:24] = sdata_q[7:0];
                2'b01: merged[23:16] = sdata_q[7:0];
                2'b10: merged[15:8]  = sdata_q[7:0];
                default: merged[7:0] = sdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[15:0] = sdata_q;
        end else begin
            merged[31:16] = sdata_q;
        end
    end

    // Sequencer FSM with registered memory strobes and status outputs
    always_ff @(posedge LoadStore_CLOCK_50) begin
        if (LoadStore_RESET_InHigh) begin
            state                    <= IDLE;
            cnt                      <= 4'd0;
            lane_q                   <= 2'b00;
            size_q                   <= 2'b00;
            sgn_q                    <= 1'b0;
            wr_q                     <= 1'b0;
            sdata_q                  <= 16'h0000;
            LoadStore_MemAddress_Out <= '0;
            LoadStore_MemData_Out    <= '0;
            LoadStore_MemRD_Out      <= 1'b0;
            LoadStore_MemWR_Out      <= 1'b0;
            LoadStore_LoadData_Out   <= '0;
            LoadStore_Busy_Out       <= 1'b0;
            LoadStore_Done_Out       <= 1'b0;
            LoadStore_Error_Out      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (LoadStore_Start_In) begin
                        lane_q              <= LoadStore_Address_In[1:0];
                        size_q              <= LoadStore_Size_In;
                        sgn_q               <= LoadStore_Signed_In;
                        wr_q                <= LoadStore_Write_In;
                        sdata_q             <= LoadStore_StoreData_In[15:0];
                        cnt                 <= 4'd0;
                        LoadStore_Busy_Out  <= 1'b1;
                        LoadStore_Error_Out <= fault_in;
                        if (fault_in) begin
                            state              <= DONE;
                            LoadStore_Done_Out <= 1'b1;
                        end else if (word_store_in) begin
                            state                    <= WRITE;
                            LoadStore_MemAddress_Out <= word_addr_in;
                            LoadStore_MemData_Out    <= LoadStore_StoreData_In;
                            LoadStore_MemWR_Out      <= 1'b1;
                        end else begin
                            state                    <= READ;
                            LoadStore_MemAddress_Out <= word_addr_in;
                            LoadStore_MemRD_Out      <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt == LAST) begin
                        LoadStore_MemRD_Out <= 1'b0;
                        if (wr_q) begin
                            state                 <= WRITE;
                            LoadStore_MemData_Out <= merged;
                            LoadStore_MemWR_Out   <= 1'b1;
                        end else begin
                            state                  <= DONE;
                            LoadStore_LoadData_Out <= ext_data;
                            LoadStore_Done_Out     <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WRITE: begin
                    state               <= DONE;
                    LoadStore_MemWR_Out <= 1'b0;
                    LoadStore_Done_Out  <= 1'b1;
                end
                default: begin
                    state              <= IDLE;
                    LoadStore_Done_Out <= 1'b0;
                    LoadStore_Busy_Out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (1 and 4 wait cycles),
// a behavioural memory, a per-cycle expectation model and literals.
module tb_load_store_unit;

    typedef struct packed {
        logic        busy;
        logic        rd;
        logic        wr;
        logic        done;
        logic        err;
        logic [31:0] ld;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ca;
        logic        cw;
    } exp_t;

    logic        clk;
    logic        rst   [2];
    logic        start [2];
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] md_in [2];
    logic [31:0] maddr [2];
    logic [31:0] mdout [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] ld    [2];
    logic        busy  [2];
    logic        done  [2];
    logic        err   [2];

    logic [31:0] mem [2][64];
    logic        poke_en;
    int          poke_i;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    exp_t        q [2][$];
    logic [31:0] held_ld  [2];
    logic        held_err [2];
    int          cyc;
    int          acc_cyc  [2];
    int          done_cyc [2];
    int          wr_cnt   [2];
    int          rd_cnt   [2];
    int          done_cnt [2];
    int          checks;
    int          errors;

    load_store_unit #(.DATAWIDTH_BUS(32), .WAIT_CYCLES(1)) u1 (
        .LoadStore_CLOCK_50      (clk),
        .LoadStore_RESET_InHigh  (rst[0]),
        .LoadStore_Start_In      (start[0]),
        .LoadStore_Write_In      (write),
        .LoadStore_Size_In       (size),
        .LoadStore_Signed_In     (sgn),
        .LoadStore_Address_In    (addr),
        .LoadStore_StoreData_In  (sdata),
        .LoadStore_MemData_In    (md_in[0]),
        .LoadStore_MemAddress_Out(maddr[0]),
        .LoadStore_MemData_Out   (mdout[0]),
        .LoadStore_MemRD_Out     (rd[0]),
        .LoadStore_MemWR_Out     (wr[0]),
        .LoadStore_LoadData_Out  (ld[0]),
        .LoadStore_Busy_Out      (busy[0]),
        .LoadStore_Done_Out      (done[0]),
        .LoadStore_Error_Out     (err[0])
    );

    load_store_unit #(.DATAWIDTH_BUS(32), .WAIT_CYCLES(4)) u4 (
        .LoadStore_CLOCK_50      (clk),
        .LoadStore_RESET_InHigh  (rst[1]),
        .LoadStore_Start_In      (start[1]),
        .LoadStore_Write_In      (write),
        .LoadStore_Size_In       (size),
        .LoadStore_Signed_In     (sgn),
        .LoadStore_Address_In    (addr),
        .LoadStore_StoreData_In  (sdata),
        .LoadStore_MemData_In    (md_in[1]),
        .LoadStore_MemAddress_Out(maddr[1]),
        .LoadStore_MemData_Out   (mdout[1]),
        .LoadStore_MemRD_Out     (rd[1]),
        .LoadStore_MemWR_Out     (wr[1]),
        .LoadStore_LoadData_Out  (ld[1]),
        .LoadStore_Busy_Out      (busy[1]),
        .LoadStore_Done_Out      (done[1]),
        .LoadStore_Error_Out     (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign md_in[0] = mem[0][maddr[0][7:2]];
    assign md_in[1] = mem[1][maddr[1][7:2]];

    // Data_Memory stand-in: write port plus a bench preload port
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (wr[i] === 1'b1) mem[i][maddr[i][7:2]] <= mdout[i];
        end
        if (poke_en) mem[poke_i][poke_idx] <= poke_val;
    end

    task automatic lit(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic poke(input int i, input logic [31:0] a,
                        input logic [31:0] v);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_i   = i;
        poke_idx = a[7:2];
        poke_val = v;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    function automatic exp_t ent(input logic b, input logic r,
                                 input logic w, input logic d,
                                 input logic e, input logic [31:0] l,
                                 input logic [31:0] a,
                                 input logic [31:0] wd);
        exp_t x;
        x.busy  = b;
        x.rd    = r;
        x.wr    = w;
        x.done  = d;
        x.err   = e;
        x.ld    = l;
        x.addr  = a;
        x.wdata = wd;
        x.ca    = r | w;
        x.cw    = w;
        return x;
    endfunction

    // Expected behaviour of one accepted request, cycle by cycle
    task automatic push(input int i, output int n);
        int          nw;
        int          sh;
        logic        fault;
        logic [31:0] wa;
        logic [31:0] wordv;
        logic [31:0] m;
        logic [31:0] v;
        logic [31:0] merged;
        nw    = (i == 0) ? 1 : 4;
        fault = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
        wa    = addr & 32'hFFFF_FFFC;
        wordv = mem[i][addr[7:2]];
        m     = (size == 2'b00) ? 32'hFF : 32'hFFFF;
        sh    = (size == 2'b00) ? (3 - int'(addr[1:0])) * 8
                                : (addr[1] ? 0 : 16);
        v     = (size == 2'b10) ? wordv : ((wordv >> sh) & m);
        if (sgn && size == 2'b00 && v[7]) v = v | 32'hFFFF_FF00;
        if (sgn && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
        merged = (wordv & ~(m << sh)) | ((sdata & m) << sh);
        n = 0;
        if (fault) begin
            q[i].push_back(ent(1, 0, 0, 1, 1, held_ld[i], 0, 0));
            q[i].push_back(ent(0, 0, 0, 0, 1, held_ld[i], 0, 0));
        end else if (write && size == 2'b10) begin
            q[i].push_back(ent(1, 0, 1, 0, 0, held_ld[i], wa, sdata));
            q[i].push_back(ent(1, 0, 0, 1, 0, held_ld[i], 0, 0));
            q[i].push_back(ent(0, 0, 0, 0, 0, held_ld[i], 0, 0));
        end else begin
            for (int k = 0; k < nw; k++)
                q[i].push_back(ent(1, 1, 0, 0, 0, held_ld[i], wa, 0));
            if (write) begin
                q[i].push_back(ent(1, 0, 1, 0, 0, held_ld[i], wa, merged));
                q[i].push_back(ent(1, 0, 0, 1, 0, held_ld[i], 0, 0));
                q[i].push_back(ent(0, 0, 0, 0, 0, held_ld[i], 0, 0));
            end else begin
                q[i].push_back(ent(1, 0, 0, 1, 0, v, 0, 0));
                q[i].push_back(ent(0, 0, 0, 0, 0, v, 0, 0));
            end
        end
        n = q[i].size();
    endtask

    task automatic run(input int i, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] d, input logic hold);
        int n;
        @(negedge clk);
        write    = w;
        size     = sz;
        sgn      = sg;
        addr     = a;
        sdata    = d;
        start[i] = 1'b1;
        @(posedge clk);
        acc_cyc[i] = cyc;
        push(i, n);
        @(negedge clk);
        if (!hold) start[i] = 1'b0;
        repeat (n - 1) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare();
        exp_t         e;
        logic [100:0] act;
        logic [100:0] req;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                q[i].delete();
                e    = '0;
                e.ca = 1'b1;
                e.cw = 1'b1;
            end else if (q[i].size() > 0) begin
                e = q[i].pop_front();
            end else begin
                e = ent(0, 0, 0, 0, held_err[i], held_ld[i], 0, 0);
            end
            held_ld[i]  = e.ld;
            held_err[i] = e.err;
            act = {busy[i], rd[i], wr[i], done[i], err[i], ld[i],
                   e.ca ? maddr[i] : 32'h0, e.cw ? mdout[i] : 32'h0};
            req = {e.busy, e.rd, e.wr, e.done, e.err, e.ld,
                   e.ca ? e.addr : 32'h0, e.cw ? e.wdata : 32'h0};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL cycle%0d inst%0d {busy,rd,wr,done,err,ld,addr,wdata}: got %h expected %h",
                         cyc, i, act, req);
            end
            if (wr[i] === 1'b1) wr_cnt[i]++;
            if (rd[i] === 1'b1) rd_cnt[i]++;
            if (done[i] === 1'b1) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
        end
    endtask

    initial begin
        int w0;
        int r0;
        int d0;
        int d1;
        checks = 0;
        errors = 0;
        cyc    = 0;
        poke_en = 1'b0;
        poke_i = 0;
        poke_idx = '0;
        poke_val = '0;
        write = 1'b0;
        size  = 2'b00;
        sgn   = 1'b0;
        addr  = '0;
        sdata = '0;
        for (int i = 0; i < 2; i++) begin
            rst[i]      = 1'b1;
            start[i]    = 1'b0;
            held_ld[i]  = '0;
            held_err[i] = 1'b0;
            acc_cyc[i]  = 0;
            done_cyc[i] = 0;
            wr_cnt[i]   = 0;
            rd_cnt[i]   = 0;
            done_cnt[i] = 0;
            for (int k = 0; k < 64; k++) mem[i][k] = 32'h0;
        end
        fork
            forever begin
                @(posedge clk);
                #1;
                compare();
            end
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        idle(2);
        lit("reset_loaddata", ld[0], 32'h0);

        poke(0, 32'h10, 32'hDEADBEEF);
        r0 = rd_cnt[0];
        run(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        lit("word_load_data", ld[0], 32'hDEADBEEF);
        lit("word_load_latency", 32'(done_cyc[0] - acc_cyc[0]), 32'd2);
        lit("word_load_rd_cycles", 32'(rd_cnt[0] - r0), 32'd1);

        poke(0, 32'h10, 32'h123456F0);
        run(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
        lit("sbyte_load", ld[0], 32'hFFFFFFF0);
        run(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
        lit("ubyte_load", ld[0], 32'h000000F0);

        poke(0, 32'h20, 32'h11223344);
        run(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 1'b0);
        lit("half_store_mem", mem[0][8], 32'h1122ABCD);
        lit("half_store_latency", 32'(done_cyc[0] - acc_cyc[0]), 32'd3);
        lit("store_keeps_loaddata", ld[0], 32'h000000F0);
        run(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0);
        lit("shalf_load", ld[0], 32'hFFFFABCD);

        w0 = wr_cnt[0];
        r0 = rd_cnt[0];
        run(0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
        lit("misalign_latency", 32'(done_cyc[0] - acc_cyc[0]), 32'd1);
        lit("misalign_error", 32'(err[0]), 32'd1);
        run(0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b0);
        lit("size11_latency", 32'(done_cyc[0] - acc_cyc[0]), 32'd1);
        lit("size11_error", 32'(err[0]), 32'd1);
        lit("fault_no_strobes", 32'(wr_cnt[0] - w0 + rd_cnt[0] - r0), 32'd0);
        lit("fault_keeps_loaddata", ld[0], 32'hFFFFABCD);

        w0 = wr_cnt[0];
        run(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1);
        d0 = done_cyc[0];
        run(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1);
        lit("held_start_gap", 32'(acc_cyc[0] - d0), 32'd1);
        idle(3);
        lit("held_start_wr_pulses", 32'(wr_cnt[0] - w0), 32'd2);
        lit("word_store_mem", mem[0][16], 32'hCAFEF00D);
        lit("store_clears_error", 32'(err[0]), 32'd0);

        poke(1, 32'h10, 32'hDEADBEEF);
        d1 = done_cnt[1];
        @(negedge clk);
        write    = 1'b0;
        size     = 2'b10;
        sgn      = 1'b0;
        addr     = 32'h10;
        start[1] = 1'b1;
        @(posedge clk);
        acc_cyc[1] = cyc;
        begin
            int n;
            push(1, n);
        end
        @(negedge clk);
        start[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        idle(6);
        lit("reset_no_done", 32'(done_cnt[1] - d1), 32'd0);
        lit("reset_busy", 32'(busy[1]), 32'd0);
        run(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        lit("w4_load_data", ld[1], 32'hDEADBEEF);
        lit("w4_load_latency", 32'(done_cyc[1] - acc_cyc[1]), 32'd5);
        run(1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 1'b0);
        lit("w4_byte_store_mem", mem[1][4], 32'hDE55BEEF);
        lit("w4_byte_store_latency", 32'(done_cyc[1] - acc_cyc[1]), 32'd6);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
